// File: rtl/com_ram_pkg.sv
// Shared types and constants for the com_tpram_pipe RAM slice.
// Also supplies a default width for the system config bus when the build does not set it.
`ifndef COM_SYS_W
`define COM_SYS_W 8
`endif

package com_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic int lane_width(input int data_w, input int strb_w);
        return data_w / strb_w;
    endfunction

endpackage

// File: rtl/com_tpram_rdpipe.sv
// Valid+data delay line used for the tail of the RAM read pipeline.
// Valid bits are reset; data holds its value whenever the incoming valid is low.
module com_tpram_rdpipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    if (STAGES == 0) begin : g_pass
        assign vld_o  = vld_i;
        assign data_o = data_i;
    end else begin : g_pipe
        logic [STAGES-1:0] vld_q;
        logic [DATA_W-1:0] data_q [STAGES];

        // Shift valid every cycle; move data only alongside a valid so idle output holds
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                vld_q[0] <= vld_i;
                if (vld_i) begin
                    data_q[0] <= data_i;
                end
                for (int i = 1; i < STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign vld_o  = vld_q[STAGES-1];
        assign data_o = data_q[STAGES-1];
    end

endmodule

// File: rtl/com_tpram_pipe.sv
// Two-port RAM with lane strobes, fixed read latency, collision handling and range trap.
// Optional post-reset clear sweep is built when COM_RAM_INIT_EN is defined.
module com_tpram_pipe
    import com_ram_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                STRB_W   = 1,
    parameter int                RD_LAT   = 1,
    parameter int                BYPASS   = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int               ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`COM_SYS_W-1:0] sys_cfg,
    input  logic [STRB_W-1:0]     wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_vld,
    output logic                  init_busy,
    output logic                  oor_err
);

    localparam int                LANE_W  = lane_width(DATA_W, STRB_W);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

    if ((DATA_W % STRB_W) != 0) begin : g_bad_strb
        $error("com_tpram_pipe: DATA_W must be a multiple of STRB_W");
    end
    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_lat
        $error("com_tpram_pipe: RD_LAT must be within 1..3");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              ready_s;
    logic              init_wr_s;
    logic [ADDR_W-1:0] init_addr_s;
    logic              wr_any_s, wr_inr_s, rd_inr_s;
    logic              wr_act_s, rd_act_s, oor_hit_s, byp_hit_s;
    logic [DATA_W-1:0] mem_word_s, rd_word_s;
    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              oor_err_q, oor_err_d;
    logic              unused_sys_cfg_s;

    assign unused_sys_cfg_s = ^sys_cfg;

`ifdef COM_RAM_INIT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

    init_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Sweep state register; any reset restarts the clear at address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sweep next state: one word per cycle, leave after the last word is written
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    state_d = INIT;
                    cnt_d   = cnt_q + ONE_ADDR;
                end
            end
            READY: begin
                state_d = READY;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign ready_s     = (state_q == READY);
    assign init_wr_s   = (state_q == INIT);
    assign init_addr_s = cnt_q;
    assign init_busy   = (state_q == INIT);
`else
    assign ready_s     = 1'b1;
    assign init_wr_s   = 1'b0;
    assign init_addr_s = '0;
    assign init_busy   = 1'b0;
`endif

    assign wr_any_s  = |wr_en;
    assign wr_inr_s  = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_inr_s  = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_act_s  = ready_s & wr_any_s & wr_inr_s;
    assign rd_act_s  = ready_s & rd_en;
    assign oor_hit_s = ready_s & ((wr_any_s & ~wr_inr_s) | (rd_en & ~rd_inr_s));
    assign byp_hit_s = (BYPASS != 0) && wr_act_s && rd_inr_s && (wr_addr == rd_addr);

    // Array port: the sweep owns it while busy, otherwise lane-strobed writes
    always_ff @(posedge clk) begin
        if (init_wr_s) begin
            mem_q[init_addr_s] <= INIT_VAL;
        end else if (wr_act_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_en[i]) begin
                    mem_q[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read word: old contents, with written lanes forwarded on a bypassed collision
    always_comb begin
        mem_word_s = '0;
        rd_word_s  = '0;
        if (rd_inr_s) begin
            mem_word_s = mem_q[rd_addr];
        end else begin
            mem_word_s = '0;
        end
        for (int i = 0; i < STRB_W; i++) begin
            rd_word_s[i*LANE_W +: LANE_W] = (byp_hit_s && wr_en[i]) ?
                wr_data[i*LANE_W +: LANE_W] : mem_word_s[i*LANE_W +: LANE_W];
        end
    end

    // Stage-1 and sticky error next state
    always_comb begin
        s1_vld_d  = rd_act_s;
        s1_data_d = s1_data_q;
        oor_err_d = oor_err_q | oor_hit_s;
        if (rd_act_s) begin
            s1_data_d = rd_word_s;
        end else begin
            s1_data_d = s1_data_q;
        end
    end

    // Stage-1 read register and out-of-range flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            oor_err_q <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            oor_err_q <= oor_err_d;
        end
    end

    com_tpram_rdpipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT - 1)
    ) u_rdpipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (s1_vld_q),
        .data_i (s1_data_q),
        .vld_o  (rd_vld),
        .data_o (rd_data)
    );

    assign oor_err = oor_err_q;

endmodule

// File: tb/tb_com_tpram_pipe.sv
// Scoreboard bench for com_tpram_pipe: two instances (RD_LAT=2 bypass, RD_LAT=3 no bypass),
// DEPTH=48, two lanes; sweep checks apply when COM_RAM_INIT_EN is defined.
`timescale 1ns/1ps
module tb_com_tpram_pipe;

    localparam int DW    = 32;
    localparam int DEP   = 48;
    localparam int SW    = 2;
    localparam int AW    = 6;
    localparam int LAT_A = 2;
    localparam int LAT_B = 3;
`ifdef COM_RAM_INIT_EN
    localparam int SWEEP = DEP;
`else
    localparam int SWEEP = 0;
`endif

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b1;
    logic [`COM_SYS_W-1:0] sys_cfg = '0;
    logic [SW-1:0]         wr_en   = '0;
    logic [AW-1:0]         wr_addr = '0;
    logic [DW-1:0]         wr_data = '0;
    logic                  rd_en   = 1'b0;
    logic [AW-1:0]         rd_addr = '0;
    logic [DW-1:0]         rd_data_a, rd_data_b;
    logic                  rd_vld_a, rd_vld_b, init_busy_a, init_busy_b, oor_err_a, oor_err_b;

    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    com_tpram_pipe #(.DATA_W(DW), .DEPTH(DEP), .STRB_W(SW), .RD_LAT(LAT_A), .BYPASS(1),
                     .INIT_VAL(32'h0000_00A5)) dut_a (
        .clk(clk), .rst_n(rst_n), .sys_cfg(sys_cfg), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_vld(rd_vld_a), .init_busy(init_busy_a), .oor_err(oor_err_a));

    com_tpram_pipe #(.DATA_W(DW), .DEPTH(DEP), .STRB_W(SW), .RD_LAT(LAT_B), .BYPASS(0),
                     .INIT_VAL(32'h0000_00A5)) dut_b (
        .clk(clk), .rst_n(rst_n), .sys_cfg(sys_cfg), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_vld(rd_vld_b), .init_busy(init_busy_b), .oor_err(oor_err_b));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for instance A
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rd_vld_a) begin
            if (q_a.size() == 0) begin
                chk("a_spurious_vld", 32'(rd_vld_a), 32'd0);
            end else begin
                e = q_a.pop_front();
                chk("a_rd_data", rd_data_a, e.data);
                chk("a_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (q_a.size() != 0 && q_a[0].due < cyc) begin
            e = q_a.pop_front();
            chk("a_missing_vld", 32'(rd_vld_a), 32'd1);
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rd_vld_b) begin
            if (q_b.size() == 0) begin
                chk("b_spurious_vld", 32'(rd_vld_b), 32'd0);
            end else begin
                e = q_b.pop_front();
                chk("b_rd_data", rd_data_b, e.data);
                chk("b_rd_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (q_b.size() != 0 && q_b[0].due < cyc) begin
            e = q_b.pop_front();
            chk("b_missing_vld", 32'(rd_vld_b), 32'd1);
        end
    end

    task automatic drive(input logic [1:0] we, input logic [5:0] wa, input logic [31:0] wd,
                         input logic re, input logic [5:0] ra,
                         input logic [31:0] ea, input logic [31:0] eb);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (re) begin
            q_a.push_back('{data: ea, due: cyc + LAT_A});
            q_b.push_back('{data: eb, due: cyc + LAT_B});
        end
    endtask

    task automatic idle_inputs();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        chk("rst_rd_vld_a", 32'(rd_vld_a), 32'd0);
        chk("rst_rd_vld_b", 32'(rd_vld_b), 32'd0);
        chk("rst_rd_data_a", rd_data_a, 32'h0);
        chk("rst_rd_data_b", rd_data_b, 32'h0);
        chk("rst_oor_a", 32'(oor_err_a), 32'd0);
        chk("rst_oor_b", 32'(oor_err_b), 32'd0);
        chk("rst_busy_a", 32'(init_busy_a), 32'(SWEEP != 0));
        chk("rst_busy_b", 32'(init_busy_b), 32'(SWEEP != 0));
    endtask

    // Release reset and count busy cycles while offering reads and an out-of-range write
    task automatic release_count();
        int na;
        int nb;
        na = 0;
        nb = 0;
        @(negedge clk);
        rst_n   = 1'b1;
        wr_en   = 2'b11;
        wr_addr = 6'd50;
        wr_data = 32'hFFFF_FFFF;
        rd_en   = 1'b1;
        rd_addr = 6'd0;
        for (int k = 0; k < 200 && (init_busy_a || init_busy_b); k++) begin
            if (init_busy_a) na++;
            if (init_busy_b) nb++;
            @(negedge clk);
        end
        idle_inputs();
        chk("sweep_len_a", 32'(na), 32'(SWEEP));
        chk("sweep_len_b", 32'(nb), 32'(SWEEP));
        chk("sweep_oor_a", 32'(oor_err_a), 32'd0);
        chk("sweep_oor_b", 32'(oor_err_b), 32'd0);
    endtask

    function automatic logic [31:0] fill_exp(input int i);
`ifdef COM_RAM_INIT_EN
        return 32'h0000_00A5;
`else
        return 32'h0000_0100 + 32'(i);
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        reset_pulse();
        release_count();

`ifdef COM_RAM_INIT_EN
        drive(2'b00, 6'd0, 32'h0, 1'b1, 6'd0,  32'h0000_00A5, 32'h0000_00A5);
        drive(2'b00, 6'd0, 32'h0, 1'b1, 6'd47, 32'h0000_00A5, 32'h0000_00A5);
        drive(2'b00, 6'd0, 32'h0, 1'b1, 6'd23, 32'h0000_00A5, 32'h0000_00A5);
        reset_pulse();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        reset_pulse();
        release_count();
`endif

        // Write-to-read, lane strobes, collisions
        drive(2'b11, 6'd5, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'h0, 32'h0);
        drive(2'b11, 6'd3, 32'h1111_2222, 1'b1, 6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        drive(2'b10, 6'd3, 32'hAAAA_BBBB, 1'b0, 6'd0, 32'h0, 32'h0);
        drive(2'b11, 6'd7, 32'h0000_0009, 1'b1, 6'd3, 32'hAAAA_2222, 32'hAAAA_2222);
        drive(2'b11, 6'd7, 32'h0000_0005, 1'b1, 6'd7, 32'h0000_0005, 32'h0000_0009);
        drive(2'b01, 6'd7, 32'h1234_5678, 1'b1, 6'd7, 32'h0000_5678, 32'h0000_0005);
        drive(2'b11, 6'd2, 32'h2222_0002, 1'b1, 6'd7, 32'h0000_5678, 32'h0000_5678);
        drive(2'b00, 6'd0, 32'h0,         1'b1, 6'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk("oor_clean_a", 32'(oor_err_a), 32'd0);
        chk("oor_clean_b", 32'(oor_err_b), 32'd0);

        // Out-of-range write dropped and flagged, out-of-range read returns zero
        drive(2'b11, 6'd50, 32'hFFFF_FFFF, 1'b1, 6'd3, 32'hAAAA_2222, 32'hAAAA_2222);
        drive(2'b00, 6'd0,  32'h0,         1'b1, 6'd2, 32'h2222_0002, 32'h2222_0002);
        chk("oor_wr_a", 32'(oor_err_a), 32'd1);
        chk("oor_wr_b", 32'(oor_err_b), 32'd1);
        drive(2'b00, 6'd0, 32'h0, 1'b1, 6'd50, 32'h0, 32'h0);
        drive(2'b00, 6'd0, 32'h0, 1'b0, 6'd0,  32'h0, 32'h0);
        chk("oor_sticky_a", 32'(oor_err_a), 32'd1);
        chk("oor_sticky_b", 32'(oor_err_b), 32'd1);

        // Fill 0..9, stream reads, reset with reads in flight
        for (int i = 0; i < 10; i++) begin
            drive(2'b11, 6'(i), 32'h0000_0100 + 32'(i), 1'b0, 6'd0, 32'h0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 6'd0, 32'h0, 1'b1, 6'(i), 32'h0000_0100 + 32'(i), 32'h0000_0100 + 32'(i));
        end
        reset_pulse();
        release_count();
        for (int i = 4; i < 10; i++) begin
            drive(2'b00, 6'd0, 32'h0, 1'b1, 6'(i), fill_exp(i), fill_exp(i));
        end

        // A lone out-of-range read also sets the flag
        drive(2'b00, 6'd0, 32'h0, 1'b1, 6'd50, 32'h0, 32'h0);
        drive(2'b00, 6'd0, 32'h0, 1'b0, 6'd0,  32'h0, 32'h0);
        chk("oor_rd_a", 32'(oor_err_a), 32'd1);
        chk("oor_rd_b", 32'(oor_err_b), 32'd1);

        repeat (6) drive(2'b00, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 32'h0);
        chk("drain_a", 32'(q_a.size()), 32'd0);
        chk("drain_b", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
